mobo_mem_responder: RTL and testbench
=====================================

# mobo_mem_responder

Responder (slave) end of the CPU↔motherboard request/acknowledge bus; the CPU's read/write routines talk to it. It decodes `mobo_ctrl`, holds the request, inserts a fixed number of wait states and performs a single-word access to an internal word-addressed memory. It then reports completion on `mobo_stat` with a four-phase handshake. It sits on the motherboard side of the `addr`, `mobodat_out` and `mobodat_in` register links.

## Interface
- `word_width`, default `WORD_WIDTH` (16): width of every bus word.
- `ADDR_BITS`, default 8: memory depth is 2**ADDR_BITS words.
- `WAIT_CYCLES`, default 2: wait states inserted before the access (0 allowed).
- `ROM_WORDS`, default 16: size of the write-protected low region (used only with the macro below).
- `clk`: in, 1. Clock `clk`.
- `rst`: in, 1. Reset `rst`, synchronous, active-low.
- `mobo_ctrl`: in, word_width. Bit0 REQ, bit1 WE (1 = write, 0 = read). Other bits are ignored.
- `addr_in`: in, word_width. Word address, driven from the CPU address register.
- `wdata_in`: in, word_width. Write data, driven from the CPU data-out register.
- `mobo_stat`: out, word_width. Bit0 BUSY, bit1 DONE, bit2 ERR. Other bits are always 0.
- `rdata_out`: out, word_width. Read data, driven to the CPU data-in register.

## Operation
- States: IDLE, WAIT, ACCESS, DONE. All are registered, and the outputs are decoded from registers.
- IDLE: BUSY=0, DONE=0. On a clock edge with REQ=1:
  - latch `addr_in`, WE and `wdata_in`;
  - load the wait counter with WAIT_CYCLES;
  - go to WAIT, or directly to ACCESS if WAIT_CYCLES=0.
- WAIT: BUSY=1. The counter decrements each cycle; leave for ACCESS on the edge where the counter is 1.
- ACCESS: BUSY=1, for exactly one cycle. On the exit edge:
  - Out of range (latched addr ≥ 2**ADDR_BITS): no write, `rdata_out`←0, ERR←1.
  - Read: `rdata_out`←mem[addr], ERR←0.
  - Write: mem[addr]←latched wdata, ERR←0. `rdata_out` is unchanged.
  - In all cases go to DONE.
- DONE: DONE=1, BUSY=0, ERR holds its value. Stay while REQ=1. On an edge with REQ=0, go to IDLE, clearing DONE and ERR.
- Latched values are used throughout. Changes on `addr_in`/`wdata_in`/WE after the sampling edge have no effect.
- REQ dropping during WAIT/ACCESS does not abort the access. It completes, DONE is asserted for one cycle, then the block returns to IDLE.
- `rdata_out` holds the last read value until the next read or reset.
- Memory contents are not reset. A read of a never-written word is undefined, and benches write before they read.

## Timing
- Reset (edge with rst=0) takes priority over everything:
  - state←IDLE;
  - `mobo_stat`←0, `rdata_out`←0, wait counter←0;
  - an access in flight is dropped, with no write even on the ACCESS exit edge.
- Latency: if REQ is sampled at edge E0, DONE is visible after edge E0+WAIT_CYCLES+1. That is 3 cycles with the defaults, 1 cycle with WAIT_CYCLES=0.
- Read data is valid in the same cycle DONE first goes high and stays stable while DONE=1.
- Handshake release: REQ sampled low at edge Ed gives DONE=0 after Ed.
- Back-to-back: a new REQ is sampled no earlier than the edge after returning to IDLE. At least one IDLE cycle separates transactions.
- Throughput with a CPU that drops REQ the cycle it sees DONE: one transaction per WAIT_CYCLES+3 cycles.

## Configuration
- `MOBO_MEM_WPROT_EN` defined: a write to addr < ROM_WORDS is not performed and sets ERR=1 with normal DONE timing. Reads of that region are unaffected.
- Not defined: the whole in-range address space is writable, ROM_WORDS is unused, and ERR means out of range only.

## Test plan
- Reset and idle:
  - Hold rst=0 for 3 cycles with REQ=1 → `mobo_stat`=0, `rdata_out`=0.
  - Release with REQ=0 → stays IDLE.
- Write then read (defaults):
  - Write 0x1234 to addr 0x20 → BUSY for 3 cycles, then DONE 3 cycles after the sampling edge.
  - Drop REQ, then read addr 0x20 → `rdata_out`=0x1234 with DONE, ERR=0.
- WAIT_CYCLES=0:
  - Read addr 0x20 → DONE 1 cycle after the sampling edge.
  - Hold REQ for 5 cycles → DONE stays 1, `rdata_out` stable, next transaction not accepted until REQ low plus one IDLE cycle.
- Out of range:
  - Read addr 0x100 (ADDR_BITS=8) → ERR=1, DONE=1, `rdata_out`=0.
  - Write 0xBEEF to 0x100 → ERR=1, and no alias write at 0x00 (a later read of 0x00 returns the prior value).
- Reset mid-operation:
  - Write 0xAAAA to addr 0x30 (holding 0x5555), assert rst=0 during ACCESS → `mobo_stat`=0.
  - Reading 0x30 after reset returns 0x5555.
- `MOBO_MEM_WPROT_EN`:
  - Write 0x7777 to addr 0x05 → ERR=1, and a read of 0x05 returns the prior value.
  - The same write with the macro undefined → ERR=0 and the read returns 0x7777.

Source files
------------

// File: rtl/mobo_mem_responder.sv
// Motherboard-side responder for the CPU request/acknowledge bus: decodes mobo_ctrl, inserts wait
// states, performs one word access to internal memory and handshakes on mobo_stat. Optional: MOBO_MEM_WPROT_EN.
module mobo_mem_responder #(
  parameter int word_width  = 16,
  parameter int ADDR_BITS   = 8,
  parameter int WAIT_CYCLES = 2,
  parameter int ROM_WORDS   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [word_width-1:0] mobo_ctrl,
  input  logic [word_width-1:0] addr_in,
  input  logic [word_width-1:0] wdata_in,
  output logic [word_width-1:0] mobo_stat,
  output logic [word_width-1:0] rdata_out
);

  localparam int CW = $clog2(WAIT_CYCLES + 2);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE} state_t;

  state_t                state;
  logic [word_width-1:0] addr_q;
  logic [word_width-1:0] wdata_q;
  logic                  we_q;
  logic [CW-1:0]         wait_cnt;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic [word_width-1:0] mem [0:2**ADDR_BITS-1];

  logic                 req;
  logic                 in_range;
  logic                 wprot;
  logic                 do_write;
  logic [ADDR_BITS-1:0] idx;
  logic                 unused_ctrl;

  assign req         = mobo_ctrl[0];
  assign unused_ctrl = ^mobo_ctrl[word_width-1:2];
  assign idx         = addr_q[ADDR_BITS-1:0];
  // Any set bit above the memory index means the address has no backing word (no aliasing).
  assign in_range    = (addr_q >> ADDR_BITS) == '0;

`ifdef MOBO_MEM_WPROT_EN
  assign wprot = we_q && (addr_q < word_width'(ROM_WORDS));
`else
  logic unused_rom_words;
  assign wprot            = 1'b0;
  assign unused_rom_words = (ROM_WORDS != 0);
`endif

  // Reset on the ACCESS exit edge must suppress the write, so rst gates the enable.
  assign do_write = rst && (state == S_ACCESS) && we_q && in_range && !wprot;

  always_ff @(posedge clk) begin
    if (do_write) mem[idx] <= wdata_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      wait_cnt  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      rdata_out <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            addr_q   <= addr_in;
            wdata_q  <= wdata_in;
            we_q     <= mobo_ctrl[1];
            wait_cnt <= CW'(WAIT_CYCLES);
            busy     <= 1'b1;
            state    <= (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
          end
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt - CW'(1);
          if (wait_cnt == CW'(1)) state <= S_ACCESS;
        end
        S_ACCESS: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= S_DONE;
          if (!in_range) begin
            rdata_out <= '0;
            err       <= 1'b1;
          end else if (we_q) begin
            err <= wprot;
          end else begin
            rdata_out <= mem[idx];
            err       <= 1'b0;
          end
        end
        S_DONE: begin
          if (!req) begin
            done  <= 1'b0;
            err   <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign mobo_stat = {{(word_width-3){1'b0}}, err, done, busy};

endmodule

// File: tb/tb_mobo_mem_responder.sv
// Scoreboard bench for mobo_mem_responder: stimulus pushes model expectations, a negedge monitor
// pops them when DONE rises. Honours MOBO_MEM_WPROT_EN in its reference model.
module tb_mobo_mem_responder;

  localparam int W           = 16;
  localparam int ADDR_BITS   = 8;
  localparam int WAIT_CYCLES = 2;
  localparam int ROM_WORDS   = 16;
  localparam int DEPTH       = 2**ADDR_BITS;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] mobo_ctrl = '0;
  logic [W-1:0] addr_in = '0;
  logic [W-1:0] wdata_in = '0;
  logic [W-1:0] mobo_stat;
  logic [W-1:0] rdata_out;

  mobo_mem_responder #(
    .word_width (W),
    .ADDR_BITS  (ADDR_BITS),
    .WAIT_CYCLES(WAIT_CYCLES),
    .ROM_WORDS  (ROM_WORDS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .mobo_ctrl(mobo_ctrl),
    .addr_in  (addr_in),
    .wdata_in (wdata_in),
    .mobo_stat(mobo_stat),
    .rdata_out(rdata_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           cyc;
    bit           err;
    logic [W-1:0] rdata;
    bit           rdata_known;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit prev_done = 1'b0;

  // Reference model: plain word array plus knowledge flags for words never written.
  logic [W-1:0] model_mem [DEPTH];
  bit           model_known [DEPTH];
  logic [W-1:0] model_rd = '0;
  bit           model_rd_known = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (mobo_stat[1] && !prev_done) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_done", 16'd1, 16'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("latency", W'(cyc - e.cyc), W'(WAIT_CYCLES + 1));
        checkOutput("err", W'(mobo_stat[2]), W'(e.err));
        checkOutput("busy_at_done", W'(mobo_stat[0]), 16'd0);
        checkOutput("stat_high_bits", W'(mobo_stat[W-1:3]), 16'd0);
        if (e.rdata_known) checkOutput("rdata", rdata_out, e.rdata);
      end
    end else if (exp_q.size() != 0 && !mobo_stat[1]) begin
      checkOutput("busy_in_flight", W'(mobo_stat[0]), 16'd1);
    end
    prev_done = mobo_stat[1];
  end

  function automatic exp_t modelAccess(input bit we, input logic [W-1:0] a, input logic [W-1:0] d);
    exp_t e;
    bit   prot;
    int   ai;
    ai   = int'(a);
`ifdef MOBO_MEM_WPROT_EN
    prot = we && (ai < ROM_WORDS);
`else
    prot = 1'b0;
`endif
    e.cyc = 0;
    if (ai >= DEPTH) begin
      e.err          = 1'b1;
      model_rd       = '0;
      model_rd_known = 1'b1;
    end else if (we) begin
      e.err = prot;
      if (!prot) begin
        model_mem[ai]   = d;
        model_known[ai] = 1'b1;
      end
    end else begin
      e.err          = 1'b0;
      model_rd       = model_mem[ai];
      model_rd_known = model_known[ai];
    end
    e.rdata       = model_rd;
    e.rdata_known = model_rd_known;
    return e;
  endfunction

  task automatic driveReq(input bit req, input bit we);
    mobo_ctrl    = W'($urandom);
    mobo_ctrl[1] = we;
    mobo_ctrl[0] = req;
  endtask

  // One full transaction; hold = cycles REQ stays high after DONE, negative = drop REQ right after sampling.
  task automatic applyStimulus(input bit we, input logic [W-1:0] a, input logic [W-1:0] d, input int hold);
    exp_t         e;
    bit           got;
    int           waited;
    logic [W-1:0] rd;
    e = modelAccess(we, a, d);
    @(negedge clk);
    driveReq(1'b1, we);
    addr_in  = a;
    wdata_in = d;
    @(posedge clk);
    #1;
    e.cyc = cyc;
    exp_q.push_back(e);
    addr_in  = W'($urandom);
    wdata_in = W'($urandom);
    driveReq(hold >= 0, $urandom_range(0, 1) == 1);
    got    = 1'b0;
    waited = 0;
    while (!got && waited < WAIT_CYCLES + 8) begin
      @(negedge clk);
      waited++;
      if (hold < 0) driveReq(1'b0, $urandom_range(0, 1) == 1);
      if (mobo_stat[1]) got = 1'b1;
    end
    if (!got) begin
      checkOutput("done_timeout", 16'd0, 16'd1);
      exp_q.delete();
    end
    rd = rdata_out;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checkOutput("done_hold", W'(mobo_stat[1]), 16'd1);
      checkOutput("busy_hold", W'(mobo_stat[0]), 16'd0);
      checkOutput("rdata_stable", rdata_out, rd);
    end
    if (hold >= 0) begin
      @(negedge clk);
      driveReq(1'b0, $urandom_range(0, 1) == 1);
    end
    @(posedge clk);
    #1;
    checkOutput("release_stat", mobo_stat, 16'd0);
  endtask

  // Start a write, then assert reset so it is sampled on the ACCESS exit edge.
  task automatic resetDuringAccess(input logic [W-1:0] a, input logic [W-1:0] d);
    @(negedge clk);
    driveReq(1'b1, 1'b1);
    addr_in  = a;
    wdata_in = d;
    @(posedge clk);
    #1;
    repeat (WAIT_CYCLES) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midreset_stat", mobo_stat, 16'd0);
    checkOutput("midreset_rdata", rdata_out, 16'd0);
    @(negedge clk);
    driveReq(1'b0, 1'b0);
    rst            = 1'b1;
    model_rd       = '0;
    model_rd_known = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      model_mem[i]   = '0;
      model_known[i] = 1'b0;
    end

    rst       = 1'b0;
    mobo_ctrl = 16'h0003;
    addr_in   = 16'h0020;
    wdata_in  = 16'hFFFF;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_stat", mobo_stat, 16'd0);
    checkOutput("reset_rdata", rdata_out, 16'd0);
    @(negedge clk);
    mobo_ctrl = '0;
    rst       = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("idle_stat", mobo_stat, 16'd0);

    applyStimulus(1'b1, 16'h0020, 16'h1234, 0);
    applyStimulus(1'b0, 16'h0020, 16'h0000, 0);
    applyStimulus(1'b0, 16'h0020, 16'h0000, 5);

    applyStimulus(1'b1, 16'h0000, 16'h0042, 0);
    applyStimulus(1'b0, 16'h0100, 16'h0000, 1);
    applyStimulus(1'b1, 16'h0100, 16'hBEEF, 0);
    applyStimulus(1'b0, 16'h0000, 16'h0000, 0);
    applyStimulus(1'b1, 16'h0120, 16'hBEEF, 0);
    applyStimulus(1'b0, 16'h0020, 16'h0000, 0);

    applyStimulus(1'b1, 16'h0030, 16'h5555, 0);
    resetDuringAccess(16'h0030, 16'hAAAA);
    applyStimulus(1'b0, 16'h0030, 16'h0000, 0);

    applyStimulus(1'b1, 16'h0005, 16'h7777, 0);
    applyStimulus(1'b0, 16'h0005, 16'h0000, 0);

    applyStimulus(1'b0, 16'h0030, 16'h0000, -1);
    applyStimulus(1'b1, 16'h00FF, 16'hC0DE, -1);
    applyStimulus(1'b0, 16'h00FF, 16'h0000, 2);

    for (int n = 0; n < 60; n++) begin
      logic [W-1:0] a;
      int           hold;
      if ($urandom_range(0, 7) == 0) a = W'($urandom_range(DEPTH, 65535));
      else                           a = W'($urandom_range(0, 47));
      hold = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 3));
      applyStimulus($urandom_range(0, 1) == 1, a, W'($urandom), hold);
    end

    repeat (3) @(posedge clk);
    #1;
    checkOutput("queue_drained", W'(exp_q.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
